// File: rtl/or_stim_checker_if.sv
// rtl/or_stim_checker_if.sv - gate-side and status signals of the OR gate stimulus checker
interface or_stim_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             c;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    input  start, c,
    output a, b, busy, done, pass, err_cnt
  );

  modport slave (
    output start, c,
    input  a, b, busy, done, pass, err_cnt
  );
endinterface

// File: rtl/or_stim_checker.sv
// rtl/or_stim_checker.sv - clocked sweep of the 2-input OR gate with end-of-hold compare
// Optional ORSTIM_LFSR_EN appends RAND_VECTORS pseudo-random vectors after the exhaustive four.
module or_stim_checker #(
  parameter int unsigned HOLD_CYCLES  = 10,
  parameter int unsigned ERR_W        = 8,
  parameter int unsigned RAND_VECTORS = 16
) (
  input logic               clk,
  input logic               rst,
  or_stim_checker_if.master bus
);

`ifdef ORSTIM_LFSR_EN
  localparam int unsigned NUM_RAND = RAND_VECTORS;
`else
  localparam int unsigned NUM_RAND = 0 * RAND_VECTORS;
`endif
  localparam int unsigned NUM_VEC = 4 + NUM_RAND;
  localparam int unsigned HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned VW      = $clog2(NUM_VEC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [VW-1:0] VEC_LAST  = VW'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state_q, state_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic             mismatch;
  logic [ERR_W-1:0] err_sat;
`ifdef ORSTIM_LFSR_EN
  logic [7:0]       lfsr_q, lfsr_d;
  logic [7:0]       lfsr_step;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

  assign mismatch = (bus.c != (a_q | b_q));
  assign err_sat  = (mismatch && (err_q != {ERR_W{1'b1}})) ? err_q + ERR_W'(1) : err_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
`ifdef ORSTIM_LFSR_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = DRIVE;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          hold_d  = '0;
          vec_d   = '0;
`ifdef ORSTIM_LFSR_EN
          lfsr_d  = 8'hA5;
`endif
        end
      end
      DRIVE: begin
        hold_d = hold_q + HW'(1);
        // c is only trusted at the last cycle of a hold, after the gate has settled
        if (hold_q == HOLD_LAST) begin
          err_d  = err_sat;
          hold_d = '0;
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_sat == '0);
          end else begin
            vec_d = vec_q + VW'(1);
`ifdef ORSTIM_LFSR_EN
            if (vec_q >= VW'(3)) begin
              lfsr_d = lfsr_step;
              a_d    = lfsr_step[0];
              b_d    = lfsr_step[1];
            end else begin
              a_d = vec_d[1];
              b_d = vec_d[0];
            end
`else
            a_d = vec_d[1];
            b_d = vec_d[0];
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      hold_q  <= '0;
      vec_q   <= '0;
`ifdef ORSTIM_LFSR_EN
      lfsr_q  <= 8'hA5;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
`ifdef ORSTIM_LFSR_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_or_stim_checker.sv
// tb/tb_or_stim_checker.sv - self-checking bench for or_stim_checker with behavioural gate models
module tb_or_stim_checker;

  typedef struct {
    int mode;
    int exp_err;
    bit exp_pass;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode0 = 0;
  int   mode1 = 0;
  int   nchecks = 0;
  int   nerr = 0;
  vec_t exp_q[$];
  vec_t tbl[5];

  always #5 clk = ~clk;

  // 0: OR, 1: stuck-at-0, 2: stuck-at-1, 3: AND, 4: XOR
  function automatic logic gate(input int mode, input logic a, input logic b);
    case (mode)
      0: return a | b;
      1: return 1'b0;
      2: return 1'b1;
      3: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  or_stim_checker_if #(.ERR_W(8)) bus0 ();
  or_stim_checker_if #(.ERR_W(1)) bus1 ();

  assign bus0.c = gate(mode0, bus0.a, bus0.b);
  assign bus1.c = gate(mode1, bus1.a, bus1.b);

  or_stim_checker #(.HOLD_CYCLES(10), .ERR_W(8), .RAND_VECTORS(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  or_stim_checker #(.HOLD_CYCLES(1), .ERR_W(1), .RAND_VECTORS(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sweep0(input vec_t v, input int pulse_at);
    int bad;
    int cyc;
    vec_t e;
    exp_q.push_back(v);
    mode0 = v.mode;
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start = 1'b0;
    check("start_clears", {bus0.done, bus0.pass, bus0.err_cnt}, 0);
    bad = 0;
    cyc = 0;
    while (!bus0.done && cyc < 60) begin
      if (bus0.busy !== 1'b1 || {bus0.a, bus0.b} !== 2'(cyc / 10)) bad++;
      bus0.start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    bus0.start = 1'b0;
    check("ab_busy_seq", bad, 0);
    check("done_latency", cyc, 40);
    e = exp_q.pop_front();
    check("err_cnt", bus0.err_cnt, e.exp_err);
    check("pass", bus0.pass, e.exp_pass);
    check("done_state_ab_busy", {bus0.a, bus0.b, bus0.busy}, 3'b110);
    repeat (5) @(negedge clk);
    check("done_held", {bus0.done, bus0.pass, bus0.err_cnt}, {1'b1, e.exp_pass, 8'(e.exp_err)});
  endtask

  task automatic sweep1(input int mode, input int exp_err, input bit exp_pass);
    int bad;
    mode1 = mode;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if ({bus1.a, bus1.b} !== 2'(i) || bus1.busy !== 1'b1 || bus1.done !== 1'b0) bad++;
      @(negedge clk);
    end
    check("h1_ab_seq", bad, 0);
    check("h1_done", {bus1.done, bus1.busy}, 2'b10);
    check("h1_err_cnt", bus1.err_cnt, exp_err);
    check("h1_pass", bus1.pass, exp_pass);
  endtask

  initial begin
    int bad;
    tbl[0] = '{0, 0, 1'b1};
    tbl[1] = '{1, 3, 1'b0};
    tbl[2] = '{2, 1, 1'b0};
    tbl[3] = '{3, 2, 1'b0};
    tbl[4] = '{4, 1, 1'b0};
    bus0.start = 1'b0;
    bus1.start = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt} !== 12'h0) bad++;
      if ({bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt} !== 6'h0) bad++;
      @(negedge clk);
    end
    check("idle_after_reset", bad, 0);

    for (int i = 0; i < 5; i++)
      sweep0(tbl[i], (i == 2) ? 15 : -1);

    // abort mid-sweep: reset wins and no done follows
    mode0 = 0;
    bus0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (24) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_reset", {bus0.a, bus0.b, bus0.busy, bus0.done, bus0.pass, bus0.err_cnt}, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("no_done_after_abort", bad, 0);

    sweep1(0, 0, 1'b1);
    sweep1(1, 1, 1'b0);
    sweep1(3, 1, 1'b0);

    // start held high through DONE restarts immediately
    mode1 = 0;
    bus1.start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("held_start_done", {bus1.done, bus1.busy}, 2'b10);
    @(negedge clk);
    check("held_start_restart", {bus1.done, bus1.busy, bus1.a, bus1.b}, 4'b0100);
    bus1.start = 1'b0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", nerr);
    $fatal(1);
  end

endmodule

// File: doc/or_stim_checker.md
Name: or_stim_checker

Overview:
Sequential stimulus driver and self-checker that sits directly upstream of the 2-input OR gate, feeding its a and b inputs and consuming its c output. On a start pulse it steps the four input combinations, holding each for a fixed number of cycles. It compares c against a|b at the end of each hold and reports the error count and pass/fail. It replaces hand-written delay sequences with a synthesizable, clocked sweep.

Parameters:
HOLD_CYCLES, 10, clock cycles each vector is held; must be >= 1.
ERR_W, 8, width of the error counter.
RAND_VECTORS, 16, number of extra pseudo-random vectors; used only when ORSTIM_LFSR_EN is defined.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  level sampled each edge; starts a sweep when idle or done.
c  input  1  OR gate output under test (combinational from a, b).
a  output  1  OR gate input a, registered.
b  output  1  OR gate input b, registered.
busy  output  1  high while a sweep is running.
done  output  1  high once a sweep has completed; held until next start.
pass  output  1  valid when done=1; 1 iff err_cnt==0.
err_cnt  output  ERR_W  mismatches in current/last sweep, saturating.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, hold counter=0. Applies in every state, including mid-sweep. No done is produced for an aborted sweep.
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE or DONE with start=1 at edge k:
  - Next state DRIVE; {a,b}=2'b00; hold counter=0.
  - busy=1, done=0, pass=0, err_cnt=0.
- DRIVE:
  - The hold counter increments every edge.
  - At the edge where counter==HOLD_CYCLES-1, the checker samples c. If c != (a|b), err_cnt increments, saturating at 2^ERR_W-1.
  - At that same edge, if {a,b}!=2'b11: {a,b} increments and the counter clears to 0.
  - Otherwise: state DONE, busy=0, done=1, and pass reflects err_cnt including the final compare.
- Timing: vector n ({a,b}=n) is driven after edge k+n*HOLD_CYCLES. Its compare uses c sampled just before edge k+(n+1)*HOLD_CYCLES. done is first visible after edge k+4*HOLD_CYCLES.
- HOLD_CYCLES=1: one cycle per vector; the compare happens at every edge.
- start is ignored while busy=1.
- start held high in DONE immediately restarts a sweep.
- DONE: a and b hold 2'b11; done, pass and err_cnt hold until the next start or rst.
- The gate must settle within HOLD_CYCLES-1 cycles. The checker never samples c in the first cycle of a vector unless HOLD_CYCLES=1.

Optional Feature:
ORSTIM_LFSR_EN
- Defined:
  - After the exhaustive compare of vector 2'b11, the block stays in DRIVE for RAND_VECTORS further vectors.
  - Each vector is a=lfsr[0], b=lfsr[1], taken from an 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1.
  - The LFSR is seeded to 8'hA5 on every start and advances once per vector at the vector-change edge.
  - Each vector is held and checked identically to the exhaustive vectors.
  - done is asserted after edge k+(4+RAND_VECTORS)*HOLD_CYCLES; a and b hold their last value in DONE.
- Undefined: no LFSR logic is present; the sweep ends after 4 vectors; RAND_VECTORS is unused.

Test Plan:
1. rst for 2 cycles, start=0 for 20 cycles -> a=0, b=0, busy=0, done=0, pass=0, err_cnt=0 throughout.
2. Correct OR model, HOLD_CYCLES=10, one-cycle start pulse -> a,b = 00,01,10,11 for 10 cycles each; busy high 40 cycles; done=1, pass=1, err_cnt=0 after edge k+40.
3. c stuck at 0 -> err_cnt=3, pass=0. c stuck at 1 -> err_cnt=1, pass=0.
4. c driven as a&b (wrong gate) -> err_cnt=2 (vectors 01 and 10), pass=0.
5. start pulsed again at cycle 15 of a sweep -> ignored; sweep ends at cycle 40. Start after done -> err_cnt clears, done drops, new sweep begins at 00.
6. rst asserted at cycle 25 of a sweep -> all outputs reach reset values after that edge; done never asserts. ERR_W=2 with 4+ forced errors (LFSR_EN) -> err_cnt saturates at 3.
